// File: rtl/proc_boot_sequencer_if.sv
// Boot-sequencer bundle: boot address and halt request in, register-file clear,
// PC load and run/status out. The master side is the sequencer.
interface proc_boot_sequencer_if #(
    parameter int unsigned AW = 5
);
    logic [31:0]   startPC;
    logic          halt_req;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [31:0]   rf_wdata;
    logic          pc_load;
    logic [31:0]   pc_value;
    logic          run;
    logic          halted;
    logic          boot_done;
    logic          fault;
    logic [31:0]   cycle_count;

    modport master (
        input  startPC, halt_req,
        output rf_we, rf_waddr, rf_wdata, pc_load, pc_value,
        output run, halted, boot_done, fault, cycle_count
    );

    modport slave (
        output startPC, halt_req,
        input  rf_we, rf_waddr, rf_wdata, pc_load, pc_value,
        input  run, halted, boot_done, fault, cycle_count
    );
endinterface

// File: rtl/proc_boot_sequencer.sv
// Processor boot sequencer: latches the boot PC during reset, clears the register
// file, loads the PC, waits out a warm-up window, then runs until halt or reset.
module proc_boot_sequencer #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned WARMUP   = 2,
    // Reset value of the RUN-cycle counter; non-zero only to reach wrap quickly.
    parameter logic [31:0] CNT_INIT = 32'h0000_0000
) (
    input logic                  CLK,
    input logic                  RESET,
    proc_boot_sequencer_if.master bus
);

    localparam int unsigned WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WW-1:0] WarmLast = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [AW-1:0] RegLast  = AW'(NREGS - 1);

    typedef enum logic [2:0] {
        StIdle, StClear, StLoad, StWarm, StRun, StHalt, StFault
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   start_q;
    logic [WW-1:0] warm_q, warm_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          pc_load_q, pc_load_d;
    logic [31:0]   pc_value_q, pc_value_d;
    logic          run_q, run_d;
    logic          halted_q, halted_d;
    logic          boot_done_q, boot_done_d;
    logic          fault_q, fault_d;
    logic [31:0]   cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        warm_d      = warm_q;
        rf_we_d     = 1'b0;
        waddr_d     = waddr_q;
        pc_load_d   = 1'b0;
        pc_value_d  = pc_value_q;
        run_d       = 1'b0;
        halted_d    = 1'b0;
        boot_done_d = boot_done_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start_q[1:0] != 2'b00) begin
                    state_d = StFault;
                    fault_d = 1'b1;
                end else begin
                    state_d = StClear;
                    rf_we_d = 1'b1;
                    waddr_d = '0;
                end
            end
            StClear: begin
                if (waddr_q == RegLast) begin
                    state_d    = StLoad;
                    pc_load_d  = 1'b1;
                    pc_value_d = start_q;
                    waddr_d    = '0;
                end else begin
                    rf_we_d = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                end
            end
            StLoad: begin
                if (WARMUP > 0) begin
                    state_d = StWarm;
                    warm_d  = '0;
                end else begin
                    state_d     = StRun;
                    run_d       = 1'b1;
                    boot_done_d = 1'b1;
                end
            end
            StWarm: begin
                if (warm_q == WarmLast) begin
                    state_d     = StRun;
                    run_d       = 1'b1;
                    boot_done_d = 1'b1;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            StRun: begin
                // The cycle in which halt is sampled still counts as a RUN cycle.
                cnt_d = cnt_q + 32'd1;
                if (bus.halt_req) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else begin
                    run_d = 1'b1;
                end
            end
            StHalt: begin
                halted_d = 1'b1;
            end
            StFault: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            start_q     <= bus.startPC;
            warm_q      <= '0;
            rf_we_q     <= 1'b0;
            waddr_q     <= '0;
            pc_load_q   <= 1'b0;
            pc_value_q  <= '0;
            run_q       <= 1'b0;
            halted_q    <= 1'b0;
            boot_done_q <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= CNT_INIT;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            rf_we_q     <= rf_we_d;
            waddr_q     <= waddr_d;
            pc_load_q   <= pc_load_d;
            pc_value_q  <= pc_value_d;
            run_q       <= run_d;
            halted_q    <= halted_d;
            boot_done_q <= boot_done_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = waddr_q;
    assign bus.rf_wdata    = '0;
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_value    = pc_value_q;
    assign bus.run         = run_q;
    assign bus.halted      = halted_q;
    assign bus.boot_done   = boot_done_q;
    assign bus.fault       = fault_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_proc_boot_sequencer.sv
// Directed bench: default build, a WARMUP=0 build and a counter-wrap build
// share one clock; expected values are hand-computed from the boot timeline.
module tb_proc_boot_sequencer;

    logic clk;
    logic rst0, rst1, rst2;
    int   n_checks;
    int   n_pass;

    proc_boot_sequencer_if #(.AW(5)) bus0 ();
    proc_boot_sequencer_if #(.AW(5)) bus1 ();
    proc_boot_sequencer_if #(.AW(5)) bus2 ();

    proc_boot_sequencer #(.NREGS(32), .AW(5), .WARMUP(2)) u_dut0 (
        .CLK   (clk),
        .RESET (rst0),
        .bus   (bus0)
    );

    proc_boot_sequencer #(.NREGS(32), .AW(5), .WARMUP(0)) u_dut1 (
        .CLK   (clk),
        .RESET (rst1),
        .bus   (bus1)
    );

    proc_boot_sequencer #(.NREGS(32), .AW(5), .WARMUP(2), .CNT_INIT(32'hFFFF_FFFE)) u_dut2 (
        .CLK   (clk),
        .RESET (rst2),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic any_active;
        n_checks = 0;
        n_pass   = 0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        bus0.startPC = 32'h0000_0100; bus0.halt_req = 1'b0;
        bus1.startPC = 32'h0000_0100; bus1.halt_req = 1'b0;
        bus2.startPC = 32'h0000_0100; bus2.halt_req = 1'b0;
        repeat (5) tick();

        check_val("rst_rf_we",     32'(bus0.rf_we),     32'd0);
        check_val("rst_rf_waddr",  32'(bus0.rf_waddr),  32'd0);
        check_val("rst_pc_load",   32'(bus0.pc_load),   32'd0);
        check_val("rst_pc_value",  bus0.pc_value,       32'd0);
        check_val("rst_run",       32'(bus0.run),       32'd0);
        check_val("rst_halted",    32'(bus0.halted),    32'd0);
        check_val("rst_boot_done", 32'(bus0.boot_done), 32'd0);
        check_val("rst_fault",     32'(bus0.fault),     32'd0);
        check_val("rst_cycles",    bus0.cycle_count,    32'd0);

        // Nominal boot: cycle 1 is the first cycle in CLEAR.
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            check_val("clr_we",    32'(bus0.rf_we),    32'd1);
            check_val("clr_waddr", 32'(bus0.rf_waddr), 32'(k - 1));
            check_val("clr_wdata", bus0.rf_wdata,      32'd0);
            check_val("clr_run",   32'(bus0.run),      32'd0);
        end
        tick();  // cycle 33
        check_val("load_strobe",  32'(bus0.pc_load), 32'd1);
        check_val("load_value",   bus0.pc_value,     32'h100);
        check_val("load_we",      32'(bus0.rf_we),   32'd0);
        check_val("load_run",     32'(bus0.run),     32'd0);
        check_val("w0_load",      32'(bus1.pc_load), 32'd1);
        tick();  // cycle 34
        check_val("warm1_strobe", 32'(bus0.pc_load), 32'd0);
        check_val("warm1_run",    32'(bus0.run),     32'd0);
        check_val("w0_run",       32'(bus1.run),     32'd1);
        check_val("w0_done",      32'(bus1.boot_done), 32'd1);
        tick();  // cycle 35
        check_val("warm2_run",    32'(bus0.run),     32'd0);
        check_val("warm2_done",   32'(bus0.boot_done), 32'd0);
        tick();  // cycle 36
        check_val("run_first",    32'(bus0.run),       32'd1);
        check_val("run_done",     32'(bus0.boot_done), 32'd1);
        check_val("run_cnt0",     bus0.cycle_count,    32'd0);
        check_val("run_pc_hold",  bus0.pc_value,       32'h100);
        check_val("wrap_a",       bus2.cycle_count,    32'hFFFF_FFFE);
        tick();
        check_val("wrap_b",       bus2.cycle_count,    32'hFFFF_FFFF);
        check_val("wrap_b_run",   32'(bus2.run),       32'd1);
        tick();
        check_val("wrap_c",       bus2.cycle_count,    32'h0000_0000);
        check_val("wrap_c_run",   32'(bus2.run),       32'd1);
        repeat (8) tick();
        check_val("cnt10",        bus0.cycle_count,    32'd10);

        // Halt after 20 counted cycles.
        repeat (10) tick();
        check_val("cnt20",        bus0.cycle_count,    32'd20);
        bus0.halt_req = 1'b1;
        tick();
        bus0.halt_req = 1'b0;
        check_val("halt_run",     32'(bus0.run),       32'd0);
        check_val("halt_flag",    32'(bus0.halted),    32'd1);
        check_val("halt_cnt",     bus0.cycle_count,    32'd21);
        check_val("halt_done",    32'(bus0.boot_done), 32'd1);
        bus0.halt_req = 1'b1;
        bus0.startPC  = 32'h0000_0300;
        repeat (2) tick();
        bus0.halt_req = 1'b0;
        check_val("halt2_flag",   32'(bus0.halted),    32'd1);
        check_val("halt2_run",    32'(bus0.run),       32'd0);
        check_val("halt2_cnt",    bus0.cycle_count,    32'd21);
        check_val("halt2_pc",     bus0.pc_value,       32'h100);

        // Reset mid-clear, then a full restart from address 0.
        rst0 = 1'b1;
        bus0.startPC = 32'h0000_0200;
        tick();
        rst0 = 1'b0;
        repeat (13) tick();
        check_val("mid_waddr",    32'(bus0.rf_waddr),  32'd12);
        rst0 = 1'b1;
        tick();
        check_val("mid_rst_we",    32'(bus0.rf_we),    32'd0);
        check_val("mid_rst_waddr", 32'(bus0.rf_waddr), 32'd0);
        check_val("mid_rst_pc",    bus0.pc_value,      32'd0);
        rst0 = 1'b0;
        bus0.halt_req = 1'b1;  // must be ignored outside RUN
        for (int k = 1; k <= 32; k++) begin
            tick();
            check_val("re_we",    32'(bus0.rf_we),    32'd1);
            check_val("re_waddr", 32'(bus0.rf_waddr), 32'(k - 1));
        end
        bus0.halt_req = 1'b0;
        tick();
        check_val("re_load",      32'(bus0.pc_load),   32'd1);
        check_val("re_value",     bus0.pc_value,       32'h200);
        repeat (3) tick();
        check_val("re_run",       32'(bus0.run),       32'd1);
        check_val("re_halted",    32'(bus0.halted),    32'd0);

        // Misaligned boot address.
        rst0 = 1'b1;
        bus0.startPC = 32'h0000_0102;
        repeat (2) tick();
        rst0 = 1'b0;
        tick();
        check_val("flt_set",      32'(bus0.fault),     32'd1);
        any_active = 1'b0;
        for (int k = 0; k < 40; k++) begin
            any_active = any_active | bus0.rf_we | bus0.pc_load | bus0.run;
            tick();
        end
        check_val("flt_quiet",    32'(any_active),     32'd0);
        check_val("flt_hold",     32'(bus0.fault),     32'd1);
        rst0 = 1'b1;
        tick();
        check_val("flt_clear",    32'(bus0.fault),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
